seq_divider: RTL and testbench

Parametrised multi-cycle integer divider: the general-division successor to the fixed divide-by-two shift block. It accepts an N-bit dividend and divisor through a valid/ready handshake and runs one restoring-division iteration per clock. It returns quotient, remainder and exception flags after a fixed latency. It sits in datapaths that need arbitrary-divisor division, signed or unsigned, where a single-cycle divider would not meet timing.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 172 +++++++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Widest operand the helper below supports; callers size-cast the result back to N bits.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] abs_operand(input logic [MAX_W-1:0] value,
                                                     input logic is_neg);
        return is_neg ? -value : value;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor_mag,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Partial remainder stays below the divisor, so an N+1-bit difference has a reliable sign bit.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor_mag};
        q_bit   = ~diff[N];
        rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider with valid/ready handshakes on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         op_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dsr_q, dsr_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          div_by_zero_q, div_by_zero_d;
    logic          overflow_q, overflow_d;

    logic          accept;
    logic          dvd_neg, dsr_neg;
    logic [N-1:0]  dvd_mag, dsr_mag;
    logic [N-1:0]  step_rem;
    logic          step_q;

    div_step #(.N(N)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[N-1]),
        .divisor_mag  (dsr_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (count_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        accept  = in_valid && in_ready;
        dvd_neg = op_signed && dividend[N-1];
        dsr_neg = op_signed && divisor[N-1];
        dvd_mag = N'(abs_operand(MAX_W'(dividend), dvd_neg));
        dsr_mag = N'(abs_operand(MAX_W'(divisor), dsr_neg));
    end

    // The dividend register doubles as the quotient register: quotient bits enter at the LSB.
    always_comb begin
        count_d       = count_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        dsr_d         = dsr_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d = CW'(N);
                    rem_d   = '0;
                    dvd_d   = dvd_mag;
                    dsr_d   = dsr_mag;
                    q_neg_d = dvd_neg ^ dsr_neg;
                    r_neg_d = dvd_neg;
                    dbz_d   = (divisor == '0);
                    ovf_d   = op_signed && (dividend == MOST_NEG) && (divisor == '1);
                end
            end
            CALC: begin
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                    rem_d   = step_rem;
                    dvd_d   = {dvd_q[N-2:0], step_q};
                end else begin
                    div_by_zero_d = dbz_q;
                    overflow_d    = ovf_q;
                    if (dbz_q) begin
                        // With a zero divisor the remainder path has shifted the dividend magnitude through untouched.
                        quotient_d  = '1;
                        remainder_d = r_neg_q ? -rem_q : rem_q;
                    end else if (ovf_q) begin
                        quotient_d  = MOST_NEG;
                        remainder_d = '0;
                    end else begin
                        quotient_d  = q_neg_q ? -dvd_q : dvd_q;
                        remainder_d = r_neg_q ? -rem_q : rem_q;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q       <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            dsr_q         <= dsr_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         op_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q, exp_r;
    logic         exp_dz, exp_ov;
    logic [N-1:0] ra, rb;
    logic         rs;
    int           sel;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .op_signed   (op_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference behaviour from plain integer arithmetic (int division truncates toward zero).
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = (b == 8'h00);
        ov = s && (a == 8'h80) && (b == 8'hFF);
        if (dz) begin
            q = 8'hFF;
            r = a;
        end else if (ov) begin
            q = a;
            r = 8'h00;
        end else if (s) begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        int waited = 0;
        model(a, b, s, exp_q, exp_r, exp_dz, exp_ov);
        dividend  = a;
        divisor   = b;
        op_signed = s;
        in_valid  = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("accept_wait", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = 8'($urandom);
        divisor   = 8'($urandom);
        op_signed = 1'($urandom);
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N + 1));
        check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'(exp_q));
            check("hold_remainder", 32'(remainder), 32'(exp_r));
            check("hold_flags", 32'({div_by_zero, overflow}), 32'({exp_dz, exp_ov}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_flags", 32'({div_by_zero, overflow}), 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        start_op(8'd200, 8'd7, 1'b0);
        wait_result("u200_7");
        release_result(0);

        start_op(8'hF9, 8'h02, 1'b1);
        wait_result("s_m7_2");
        release_result(1);

        start_op(8'h07, 8'hFE, 1'b1);
        wait_result("s_7_m2");
        release_result(0);

        start_op(8'd45, 8'd0, 1'b0);
        wait_result("u45_0");
        release_result(0);

        start_op(8'h80, 8'hFF, 1'b1);
        wait_result("s_ovf");
        release_result(0);

        start_op(8'h83, 8'h00, 1'b1);
        wait_result("s_m125_0");
        release_result(0);

        // Backpressure, then a back-to-back operand waiting during the result handshake.
        start_op(8'd100, 8'd9, 1'b0);
        wait_result("bp");
        dividend  = 8'd250;
        divisor   = 8'd13;
        op_signed = 1'b0;
        in_valid  = 1'b1;
        release_result(5);
        start_op(8'd250, 8'd13, 1'b0);
        wait_result("b2b");
        release_result(0);

        // Reset in the middle of CALC discards the operation.
        start_op(8'd100, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_quotient", 32'(quotient), 32'd0);
        check("midreset_remainder", 32'(remainder), 32'd0);
        check("midreset_flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            check("midreset_no_result", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        start_op(8'd255, 8'd16, 1'b0);
        wait_result("u255_16");
        release_result(0);

        for (int i = 0; i < 30; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rs  = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) rb = 8'h00;
            if (sel == 1) begin
                ra = 8'h80;
                rb = 8'hFF;
                rs = 1'b1;
            end
            start_op(ra, rb, rs);
            wait_result("rand");
            release_result(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
